// File: rtl/demux_1_3_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1_3_stream
// Brief    : 1-to-3 valid/ready stream demultiplexer with per-channel
//            one-entry output registers and wrapping delivered-beat counters.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1_3_stream #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  output logic [2:0]        out_valid,
  input  logic [2:0]        out_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [DATA_W-1:0] out1_data,
  output logic [DATA_W-1:0] out2_data,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic [CNT_W-1:0]  cnt2,
  output logic              sel_alias
);

  localparam int c_num_ch = 3;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic [1:0] w_ch;
  logic       w_accept;
  logic [2:0] w_load;
  logic [2:0] w_pop;
  logic       r_sel_alias;

  // Select 11 aliases onto channel 2, matching the MUX_3_1 encoding.
  always_comb begin
    w_ch = 2'd2;
    if (in_sel == 2'b00) begin
      w_ch = 2'd0;
    end else if (in_sel == 2'b01) begin
      w_ch = 2'd1;
    end
  end

  // Readiness looks only at the addressed channel, so a stall elsewhere never blocks.
  always_comb begin
    in_ready = 1'b0;
    case (w_ch)
      2'd0:    in_ready = !out_valid[0] | out_ready[0];
      2'd1:    in_ready = !out_valid[1] | out_ready[1];
      default: in_ready = !out_valid[2] | out_ready[2];
    endcase
  end

  assign w_accept = in_valid & in_ready;

  for (genvar k = 0; k < c_num_ch; k++) begin : g_ch
    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;

    assign w_load[k]    = w_accept && (w_ch == 2'(k));
    assign w_pop[k]     = (r_state == FULL) && out_ready[k];
    assign out_valid[k] = (r_state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= EMPTY;
        r_data  <= '0;
        r_cnt   <= '0;
      end else begin
        // A load wins over a pop, giving pass-through at one beat per cycle.
        case (r_state)
          EMPTY: begin
            if (w_load[k]) begin
              r_state <= FULL;
              r_data  <= in_data;
            end
          end
          FULL: begin
            if (w_load[k]) begin
              r_data <= in_data;
            end else if (w_pop[k]) begin
              r_state <= EMPTY;
            end
          end
          default: r_state <= EMPTY;
        endcase
        if (w_pop[k]) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_alias <= 1'b0;
    end else begin
      r_sel_alias <= w_accept && (in_sel == 2'b11);
    end
  end

  assign out0_data = g_ch[0].r_data;
  assign out1_data = g_ch[1].r_data;
  assign out2_data = g_ch[2].r_data;
  assign cnt0      = g_ch[0].r_cnt;
  assign cnt1      = g_ch[1].r_cnt;
  assign cnt2      = g_ch[2].r_cnt;
  assign sel_alias = r_sel_alias;

endmodule
`default_nettype wire

// File: tb/tb_demux_1_3_stream.sv
`default_nettype none
// Directed stimulus for demux_1_3_stream; expected beats are queued per channel
// on accept and a negedge monitor pops and compares them as they are delivered.
module tb_demux_1_3_stream;

  localparam int DATA_W = 3;
  localparam int CNT_W  = 2;

  typedef logic [DATA_W-1:0] data_t;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data   = '0;
  logic [1:0]        in_sel    = 2'b00;
  logic [2:0]        out_valid;
  logic [2:0]        out_ready = 3'b111;
  logic [DATA_W-1:0] out0_data;
  logic [DATA_W-1:0] out1_data;
  logic [DATA_W-1:0] out2_data;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;
  logic [CNT_W-1:0]  cnt2;
  logic              sel_alias;

  int n_vec  = 0;
  int n_fail = 0;

  data_t            q0[$];
  data_t            q1[$];
  data_t            q2[$];
  logic [CNT_W-1:0] exp_cnt [3];
  int               n_alias_set  = 0;
  int               n_alias_seen = 0;

  demux_1_3_stream #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0_data (out0_data),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .sel_alias (sel_alias)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic data_t q_front(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic data_t dut_data(input int k);
    case (k)
      0:       return out0_data;
      1:       return out1_data;
      default: return out2_data;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dut_cnt(input int k);
    case (k)
      0:       return cnt0;
      1:       return cnt1;
      default: return cnt2;
    endcase
  endfunction

  task automatic q_pop(input int k);
    case (k)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic q_push(input int k, input data_t d);
    case (k)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  // Monitor: the model says a channel holds a beat iff its queue is non-empty.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
      for (int k = 0; k < 3; k++) exp_cnt[k] = '0;
      n_alias_seen = n_alias_set;
    end else begin
      check("sel_alias", 32'(sel_alias), 32'(n_alias_set != n_alias_seen));
      n_alias_seen = n_alias_set;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(q_size(k) != 0));
        check($sformatf("cnt%0d", k), 32'(dut_cnt(k)), 32'(exp_cnt[k]));
        if (q_size(k) != 0 && out_ready[k]) begin
          check($sformatf("out%0d_data", k), 32'(dut_data(k)), 32'(q_front(k)));
          q_pop(k);
          exp_cnt[k] = exp_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Offer a beat for up to max_cyc cycles; in_ready is checked against the model each cycle.
  task automatic try_beat(input data_t d, input logic [1:0] sel, input int max_cyc, output bit acc);
    int   ch;
    logic exp_rdy;
    ch       = (sel == 2'b00) ? 0 : (sel == 2'b01) ? 1 : 2;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = sel;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      @(negedge clk);
      exp_rdy = (q_size(ch) == 0) || out_ready[ch];
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      if (exp_rdy) begin
        acc = 1'b1;
        q_push(ch, d);
        if (sel == 2'b11) n_alias_set++;
      end
    end
  endtask

  task automatic send_beat(input data_t d, input logic [1:0] sel);
    bit acc;
    try_beat(d, sel, 20, acc);
    if (!acc) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout @%0t: beat %0h sel %0b not accepted in 20 cycles", $time, d, sel);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  initial begin
    bit               acc;
    time              t0;
    logic [CNT_W-1:0] seq [5];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst out0_data", 32'(out0_data), 32'h0);
    check("rst cnt2", 32'(cnt2), 32'h0);
    check("rst sel_alias", 32'(sel_alias), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b1;

    // One beat to each channel, all consumers ready.
    send_beat(3'b101, 2'b00);
    send_beat(3'b010, 2'b01);
    send_beat(3'b110, 2'b10);
    idle(2);
    check("t1 cnt0", 32'(cnt0), 32'd1);
    check("t1 cnt1", 32'(cnt1), 32'd1);
    check("t1 cnt2", 32'(cnt2), 32'd1);

    // Select 11 lands on channel 2 and raises sel_alias for one cycle.
    send_beat(3'b110, 2'b11);
    check("t2 out_valid", 32'(out_valid), 32'b100);
    check("t2 out2_data", 32'(out2_data), 32'b110);
    check("t2 sel_alias", 32'(sel_alias), 32'h1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t2 sel_alias drop", 32'(sel_alias), 32'h0);
    check("t2 cnt2", 32'(cnt2), 32'd2);

    // in_valid low with select wandering must leave every channel alone.
    for (int i = 0; i < 4; i++) begin
      in_sel  = 2'(i);
      in_data = 3'b111;
      @(posedge clk);
      #1;
    end
    check("idle out_valid", 32'(out_valid), 32'h0);
    check("idle cnt0", 32'(cnt0), 32'd1);

    // Channel 0 stalled: second ch0 beat refused, ch1 traffic unaffected.
    out_ready = 3'b110;
    send_beat(3'b011, 2'b00);
    try_beat(3'b100, 2'b00, 3, acc);
    check("t3 ch0 refused", 32'(acc), 32'h0);
    check("t3 out0_data held", 32'(out0_data), 32'b011);
    in_valid = 1'b0;
    send_beat(3'b111, 2'b01);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t3 cnt1", 32'(cnt1), 32'd2);
    check("t3 ch0 still full", 32'(out_valid[0]), 32'h1);
    check("t3 out0_data still held", 32'(out0_data), 32'b011);
    out_ready = 3'b111;
    send_beat(3'b100, 2'b00);
    idle(2);
    check("t3 cnt0", 32'(cnt0), 32'd3);

    // Eight back-to-back beats to ch1; cnt1 goes 2 -> 10, i.e. 2 modulo 4.
    t0 = $time;
    for (int i = 0; i < 8; i++) send_beat(data_t'(i), 2'b01);
    check("t4 cycles for 8 beats", 32'($time - t0), 32'd80);
    idle(2);
    check("t4 cnt1", 32'(cnt1), 32'd2);

    // Stall ch0 and ch2 full, then reset asynchronously mid-cycle.
    out_ready = 3'b010;
    send_beat(3'b001, 2'b00);
    send_beat(3'b101, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 out_valid", 32'(out_valid), 32'h0);
    check("t6 out0_data", 32'(out0_data), 32'h0);
    check("t6 out2_data", 32'(out2_data), 32'h0);
    check("t6 cnt0", 32'(cnt0), 32'h0);
    check("t6 cnt1", 32'(cnt1), 32'h0);
    check("t6 in_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 3'b111;

    // Counter wrap with a 2-bit counter: 1,2,3,0,1.
    for (int i = 0; i < 5; i++) begin
      send_beat(data_t'(i + 1), 2'b00);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("t5 cnt0 beat %0d", i), 32'(cnt0), 32'(seq[i]));
    end

    idle(3);
    check("end q0 drained", 32'(q0.size()), 32'h0);
    check("end q1 drained", 32'(q1.size()), 32'h0);
    check("end q2 drained", 32'(q2.size()), 32'h0);
    check("end out_valid", 32'(out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
